// File: rtl/srv_defs.sv
// Shared AHB-Lite encodings and helpers for the data-memory slave and its SRAM.
package srv_defs;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_t;

  localparam logic [2:0] HSIZE_B = 3'd0;
  localparam logic [2:0] HSIZE_H = 3'd1;
  localparam logic [2:0] HSIZE_W = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian lane enables; illegal sizes enable nothing.
  function automatic logic [3:0] be_from_size(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_B: be = 4'b0001 << addr_lo;
      HSIZE_H: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      HSIZE_W: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/srv_bram.sv
// Single-port 32-bit SRAM with byte write enables and asynchronous read.
module srv_bram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            we,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [1 << DEPTH_LOG2];

  // NOTE: the array has no reset; clearing it would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/ahb_dmem_slave.sv
// AHB-Lite data-memory slave: programmable wait states, two-cycle ERROR on
// misaligned, illegal-size or out-of-range accesses, byte-writable SRAM.
module ahb_dmem_slave
  import srv_defs::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_LOG2  = 12,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam logic [32:0] MEM_BYTES = 33'd4 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_STATES - 1);

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        dphase_q, write_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q;

  logic [31:0] offset;
  logic        in_range, err_flag, accept, complete;
  logic [3:0]  mem_we;
  logic [31:0] mem_rdata;

  assign offset   = haddr - BASE_ADDR;
  assign in_range = {1'b0, offset} < MEM_BYTES;
  assign err_flag = (hsize > HSIZE_W)
                 || (hsize == HSIZE_H && haddr[0])
                 || (hsize == HSIZE_W && haddr[1:0] != 2'b00)
                 || !in_range;

  // Only IDLE and ERR2 drive hreadyout high, so this equals hready under a legal master.
  assign accept = hsel && hready && htrans[1] && (state == ST_IDLE || state == ST_ERR2);

  // An OKAY data phase completes in the IDLE cycle that still holds it.
  assign complete = (state == ST_IDLE) && dphase_q;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    hreadyout = 1'b1;
    hresp     = HRESP_OKAY;
    case (state)
      ST_IDLE, ST_ERR2: begin
        if (state == ST_ERR2) hresp = HRESP_ERROR;
        state_d = ST_IDLE;
        if (accept) begin
          if (err_flag) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        hreadyout = 1'b0;
        if (cnt == 4'd0) state_d = ST_IDLE;
        else             cnt_d   = cnt - 4'd1;
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Errored transfers never set dphase_q, which keeps them away from the SRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dphase_q <= 1'b0;
      write_q  <= 1'b0;
      size_q   <= HSIZE_B;
      addr_q   <= '0;
    end else if (accept) begin
      dphase_q <= !err_flag;
      write_q  <= hwrite;
      size_q   <= hsize;
      addr_q   <= haddr;
    end else if (state == ST_IDLE) begin
      dphase_q <= 1'b0;
    end
  end

  assign mem_we = (complete && write_q) ? be_from_size(size_q, addr_q[1:0]) : 4'b0000;
  assign hrdata = (complete && !write_q) ? mem_rdata : '0;

  // BASE_ADDR is aligned to the memory size, so the raw address bits index the array.
  srv_bram #(.DEPTH_LOG2(DEPTH_LOG2)) u_bram (
    .clk   (clk),
    .addr  (addr_q[DEPTH_LOG2+1:2]),
    .we    (mem_we),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  logic unused_ok;
  assign unused_ok = ^{hburst, hprot, hmastlock, addr_q};

endmodule

// File: tb/tb_ahb_dmem_slave.sv
// Scoreboard bench: a zero-wait and a three-wait slave driven in turn by one
// AHB master task, responses checked by an independent monitor.
module tb_ahb_dmem_slave;

  localparam int          DL    = 6;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0400;
  localparam int          WS1   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hsel0, hsel1, hwrite;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hreadyout0, hreadyout1, hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  always #5 clk = ~clk;

  ahb_dmem_slave #(.BASE_ADDR(BASE0), .DEPTH_LOG2(DL), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'b000), .hprot(4'b0011), .hmastlock(1'b0), .hwdata(hwdata),
    .hready(hreadyout0), .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_dmem_slave #(.BASE_ADDR(BASE1), .DEPTH_LOG2(DL), .WAIT_STATES(WS1)) dut1 (
    .clk(clk), .rst(rst), .hsel(hsel1), .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(3'b001), .hprot(4'b0011), .hmastlock(1'b0), .hwdata(hwdata),
    .hready(hreadyout1), .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1)
  );

  int          sel = 0;
  int          checks = 0;
  int          errors = 0;
  logic        m_rdy, m_resp;
  logic [31:0] m_data;

  assign m_rdy  = (sel == 1) ? hreadyout1 : hreadyout0;
  assign m_resp = (sel == 1) ? hresp1     : hresp0;
  assign m_data = (sel == 1) ? hrdata1    : hrdata0;

  typedef struct {
    bit          err;
    bit          is_write;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [2][64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? BASE1 : BASE0;
  endfunction

  // Error rules: illegal size, address not a multiple of the access size, or outside the window.
  function automatic bit model_err(input int d, input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b1;
    if ((a % (32'd1 << sz)) != 32'd0) return 1'b1;
    return (a - base_of(d)) >= 32'd256;
  endfunction

  // One AHB transfer: address phase held until the slave is ready, then data phase driven.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int   d = sel;
    int   n = 0;
    bit   rdy;
    exp_t e;
    int   idx, lane0;
    hsel0  = (d == 0);
    hsel1  = (d == 1);
    haddr  = a;
    htrans = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b10;
    hwrite = wr;
    hsize  = sz;
    forever begin
      @(negedge clk);
      rdy = m_rdy;
      @(posedge clk);
      if (rdy) break;
      n++;
      if (n > 100) begin
        checks++;
        errors++;
        $display("FAIL xfer_timeout: got hreadyout=0 for 100 cycles expected hreadyout=1");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
    e.err      = model_err(d, a, sz);
    e.is_write = wr;
    e.rdata    = '0;
    idx        = int'(((a - base_of(d)) >> 2) & 32'd63);
    lane0      = int'(a % 4);
    if (!e.err) begin
      if (wr) begin
        for (int i = 0; i < (1 << sz); i++)
          model[d][idx][8*(lane0+i) +: 8] = wd[8*(lane0+i) +: 8];
      end else begin
        e.rdata = model[d][idx];
      end
    end
    exp_q.push_back(e);
    #1;
    hwdata = wd;
    htrans = 2'b00;
    hsel0  = 1'b0;
    hsel1  = 1'b0;
  endtask

  task automatic idle_cyc(input logic [1:0] tr, input bit s);
    hsel0  = s && (sel == 0);
    hsel1  = s && (sel == 1);
    htrans = tr;
    haddr  = base_of(sel) + 32'(4 * $urandom_range(0, 15));
    hwrite = 1'($urandom_range(0, 1));
    hsize  = 3'd2;
    @(posedge clk);
    #1;
    htrans = 2'b00;
    hsel0  = 1'b0;
    hsel1  = 1'b0;
  endtask

  task automatic rand_phase(input int d);
    logic [31:0] a;
    logic [2:0]  sz;
    for (int i = 0; i < 16; i++) xfer(1'b1, base_of(d) + 32'(4 * i), 3'd2, $urandom);
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0:       idle_cyc(2'b00, 1'b1);
          1:       idle_cyc(2'b01, 1'b1);
          default: idle_cyc(2'b10, 1'b0);
        endcase
      end else begin
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        a  = base_of(d) + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) a = a + 32'd256;
        xfer(1'($urandom_range(0, 1)), a, sz, $urandom);
      end
    end
  endtask

  // Monitor: walks the expected response cycle by cycle for each accepted transfer.
  exp_t cur;
  bit   cur_valid = 1'b0;
  int   k = 0;

  initial begin
    int ws;
    bit last, exp_rdy, exp_resp;
    logic [31:0] exp_data;
    forever begin
      @(negedge clk);
      ws = (sel == 1) ? WS1 : 0;
      if (!rst) begin
        exp_q.delete();
        cur_valid = 1'b0;
        check("reset_hreadyout", 32'(m_rdy), 32'd1);
        check("reset_hresp", 32'(m_resp), 32'd0);
        check("reset_hrdata", m_data, 32'd0);
      end else begin
        if (!cur_valid && exp_q.size() > 0) begin
          cur       = exp_q.pop_front();
          cur_valid = 1'b1;
          k         = 0;
        end
        if (cur_valid) begin
          last     = cur.err ? (k == 1) : (k == ws);
          exp_rdy  = last;
          exp_resp = cur.err;
          exp_data = (last && !cur.err && !cur.is_write) ? cur.rdata : 32'd0;
          check(cur.err ? "err_hreadyout" : "dphase_hreadyout", 32'(m_rdy), 32'(exp_rdy));
          check(cur.err ? "err_hresp" : "dphase_hresp", 32'(m_resp), 32'(exp_resp));
          check(cur.is_write ? "wr_hrdata" : "rd_hrdata", m_data, exp_data);
          k++;
          if (last) cur_valid = 1'b0;
        end else begin
          check("idle_hreadyout", 32'(m_rdy), 32'd1);
          check("idle_hresp", 32'(m_resp), 32'd0);
          check("idle_hrdata", m_data, 32'd0);
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || cur_valid) && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check("drain_pending", 32'(exp_q.size()) + 32'(cur_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] saved;
    hsel0 = 1'b0; hsel1 = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Zero-wait slave: back-to-back write/read, lane writes, errors, idle cycles.
    sel = 0;
    xfer(1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
    xfer(1'b0, 32'h10, 3'd2, 32'h0);
    xfer(1'b1, 32'h10, 3'd2, 32'h11223344);
    xfer(1'b1, 32'h12, 3'd0, 32'h00AA0000);
    xfer(1'b0, 32'h10, 3'd2, 32'h0);
    xfer(1'b1, 32'h12, 3'd1, 32'h55660000);
    xfer(1'b0, 32'h10, 3'd2, 32'h0);
    xfer(1'b0, 32'h02, 3'd2, 32'h0);
    xfer(1'b0, 32'h100, 3'd2, 32'h0);
    xfer(1'b1, 32'h11, 3'd2, 32'hFFFFFFFF);
    xfer(1'b0, 32'h10, 3'd2, 32'h0);
    idle_cyc(2'b00, 1'b1);
    idle_cyc(2'b01, 1'b1);
    idle_cyc(2'b10, 1'b0);
    xfer(1'b0, 32'h10, 3'd2, 32'h0);
    idle_cyc(2'b01, 1'b1);
    rand_phase(0);
    drain();

    // Three-wait slave: held NONSEQ during the wait, errors below and above the window.
    sel = 1;
    xfer(1'b1, BASE1 + 32'h20, 3'd2, 32'hCAFEF00D);
    xfer(1'b0, BASE1 + 32'h20, 3'd2, 32'h0);
    xfer(1'b0, BASE1 + 32'h20, 3'd2, 32'h0);
    xfer(1'b0, BASE1 - 32'd4, 3'd2, 32'h0);
    xfer(1'b0, BASE1 + 32'h100, 3'd2, 32'h0);
    xfer(1'b1, BASE1 + 32'h30, 3'd2, 32'h12345678);
    xfer(1'b0, BASE1 + 32'h30, 3'd2, 32'h0);
    drain();

    // Reset in the second wait cycle of a write: aborted, word keeps its old value.
    saved = model[1][12];
    xfer(1'b1, BASE1 + 32'h30, 3'd2, 32'hAAAAAAAA);
    model[1][12] = saved;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_async_hreadyout", 32'(hreadyout1), 32'd1);
    check("rst_async_hresp", 32'(hresp1), 32'd0);
    check("rst_async_hrdata", hrdata1, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    xfer(1'b0, BASE1 + 32'h30, 3'd2, 32'h0);
    rand_phase(1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_dmem_slave.md
Name: ahb_dmem_slave

Overview:
AHB-Lite slave that terminates the core's data-memory bus (dmem_*) and serves it from an on-chip byte-writable SRAM. It is the responder counterpart of the core's load/store master and is used both in simulation testbenches and as the FPGA tightly-coupled data RAM. It supports programmable wait states and flags errors on misaligned or out-of-range accesses with the two-cycle AHB ERROR response.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be aligned to the memory size.
- DEPTH_LOG2, 12: log2 of the number of 32-bit words (default 16 KiB).
- WAIT_STATES, 0: extra data-phase cycles with hreadyout=0 on OKAY transfers (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous assertion, active-low.
- hsel  in  1  slave select.
- haddr  in  32  address-phase byte address.
- htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite  in  1  1 = write.
- hsize  in  3  0 = byte, 1 = half, 2 = word; 3..7 illegal.
- hburst  in  3  accepted and ignored; every beat is handled as a single transfer.
- hprot  in  4  ignored.
- hmastlock  in  1  ignored.
- hwdata  in  32  data-phase write data.
- hready  in  1  bus-level HREADY. The previous transfer completes when hready=1.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.

Behaviour:
- Transfer accept: a transfer is accepted on a clk edge with hsel && hready && htrans[1]. The slave registers addr, hwrite, hsize and err_flag.
- err_flag is set when any of these holds: hsize>2; addr misaligned (half with addr[0]=1, word with addr[1:0]!=0); addr outside [BASE_ADDR, BASE_ADDR + 4*2^DEPTH_LOG2).
- IDLE, BUSY or !hsel: these never start a data phase. If no data phase is pending, the slave drives hreadyout=1, hresp=0 (zero-wait OKAY).
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: no data phase, or a zero-wait OKAY data phase.
  - Accept with err_flag goes to ERR1.
  - Accept with WAIT_STATES>0 goes to WAIT and loads cnt=WAIT_STATES-1.
  - Accept with WAIT_STATES=0 stays in IDLE; the data phase completes in the next cycle.
  - WAIT: hreadyout=0, hresp=0. cnt decrements each cycle. At cnt==0 the next state is IDLE with a completing data phase (hreadyout=1).
  - ERR1: hreadyout=0, hresp=1. Always goes to ERR2.
  - ERR2: hreadyout=1, hresp=1. A new transfer can be accepted in this cycle and takes the normal path.
- Outputs per cycle:
  - hreadyout=1 except in WAIT and ERR1.
  - hresp=1 only in ERR1 and ERR2.
- Write commit: happens on the edge that ends an OKAY write data phase (hreadyout=1). hwdata is sampled at that edge.
- Byte enables come from hsize and addr[1:0]:
  - byte: 1 << addr[1:0]
  - half: 4'b0011 or 4'b1100
  - word: 4'b1111
- hwdata lanes: the byte/half sits on its natural lane (AHB little-endian); no shifting is done.
- Errored writes never modify memory.
- Read data: hrdata = mem[addr_q] (whole word, all lanes) during the completing cycle of an OKAY read data phase. Otherwise hrdata=0.
- Pipelining: a write followed immediately by a read of the same word returns the newly written data. The read data phase starts after the write commit edge.
- Reset: rst low asynchronously forces state=IDLE, cnt=0 and clears the pending data phase. Outputs go to hreadyout=1, hresp=0, hrdata=0.
  - Memory contents are not reset.
  - Reset in mid-WAIT aborts the transfer with no write.
- Burst types are not distinguished; SEQ is handled exactly like NONSEQ.

Decomposition:
- srv_defs gains these shared items:
  - htrans_t enum (HTRANS_IDLE/BUSY/NONSEQ/SEQ).
  - hsize_t constants (HSIZE_B/H/W).
  - HRESP_OKAY/HRESP_ERROR.
  - be_from_size() function returning a 4-bit byte enable.
- Sub-module srv_bram: a single-port 2^DEPTH_LOG2 x 32 array with 4-bit byte write enable and asynchronous read. It is separated so the FPGA flow can swap in a vendor macro.
- The FSM and address/data-phase registers live in ahb_dmem_slave.

Test Plan:
1. WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Required: both data phases have hreadyout=1, hresp=0, and the read returns 0xDEADBEEF.
2. Byte write of 0xAA on lane 2 to 0x12 over word 0x11223344. Required: a read of 0x10 returns 0x11AA3344. Half write of 0x5566 to 0x12 then reads back 0x55663344.
3. WAIT_STATES=3: a read takes exactly 3 cycles with hreadyout=0, then 1 cycle with hreadyout=1 and valid data. A second NONSEQ held during the wait is accepted only on the completing edge.
4. Word read at 0x02 (misaligned), and a read at BASE_ADDR+4*2^DEPTH_LOG2. Required for each: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1). A misaligned write leaves memory unchanged.
5. Transfers with htrans=IDLE/BUSY or hsel=0 between valid transfers. Required: no state change, hreadyout=1, hresp=0, hrdata=0.
6. Assert rst (low) during the second WAIT cycle of a write. Required: hreadyout=1 and hresp=0 immediately, the target word is unchanged, and the next transfer after release completes normally.
